rng_fifo: RTL and testbench



---
 rtl/rng_fifo.sv | 122 ++++++++++++
 tb/tb_rng_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_fifo.sv
// Prefetching show-ahead FIFO that drives the LFSR generator handshake and stocks WIDTH-bit random values.
// Latency: 5 cycles per value (IDLE, REQ, 3x WAIT); rd_data/valid/full are combinational from registered state.
// Backpressure: no request while count == DEPTH; with RNG_FIFO_REJECT_EN defined, values >= LIMIT are discarded.
module rng_fifo #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 4,
    parameter int LIMIT   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   nrst,
    input  logic                   run,
    output logic                   en_rng,
    input  logic                   done,
    input  logic [15:0]            rng_in,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [TW-1:0]    wait_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] cap;
    logic             accept;
    logic             push;
    logic             pop;
    logic             unused_rng;

    assign cap        = rng_in[WIDTH-1:0];
    assign unused_rng = ^rng_in;

`ifdef RNG_FIFO_REJECT_EN
    assign accept = (32'(cap) < 32'(LIMIT));
`else
    logic unused_limit;
    assign unused_limit = (LIMIT != 0);
    assign accept       = 1'b1;
`endif

    // A request is only issued below DEPTH and reads only shrink count, so push never overflows.
    assign push = (state == ST_WAIT) && done && accept;
    assign pop  = rd_en && (count != '0);

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            en_rng   <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run && (count < DEPTH_C)) begin
                        state  <= ST_REQ;
                        en_rng <= 1'b1;
                    end
                end
                ST_REQ: begin
                    en_rng   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    en_rng <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (nrst && push) mem[wr_ptr] <= cap;
    end

    assign valid   = (count != '0);
    assign full    = (count == DEPTH_C);
    assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_rng_fifo.sv
// Bench for rng_fifo: 3-cycle generator responder, queue scoreboard, timing vectors and corner-case sequences.
module tb_rng_fifo;
    localparam int DEPTH   = 8;
    localparam int WIDTH   = 4;
    localparam int LIMIT   = 10;
    localparam int TIMEOUT = 15;
`ifdef RNG_FIFO_REJECT_EN
    localparam bit REJECT = 1'b1;
`else
    localparam bit REJECT = 1'b0;
`endif

    typedef struct {
        logic             en;
        logic             vld;
        int               cnt;
        logic [WIDTH-1:0] rd;
    } vec_t;

    logic                   clock = 1'b0;
    logic                   nrst;
    logic                   run;
    logic                   done;
    logic                   rd_en;
    logic                   en_rng;
    logic                   valid;
    logic                   full;
    logic                   err;
    logic [15:0]            rng_in;
    logic [WIDTH-1:0]       rd_data;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic             stuck;
    logic             sb_on;
    logic             gen_busy;
    logic             gen_step;
    logic             gen_fresh;
    logic             en_prev = 1'b0;
    logic [15:0]      gen_q[$];
    logic [WIDTH-1:0] exp_q[$];
    vec_t             vecs[7];

    rng_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LIMIT(LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .nrst   (nrst),
        .run    (run),
        .en_rng (en_rng),
        .done   (done),
        .rng_in (rng_in),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .valid  (valid),
        .full   (full),
        .count  (count),
        .err    (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for a condition; returns at the negedge where it holds.
    task automatic wait_for(input int what, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clock);
            case (what)
                0:       hit = (count == 1);
                1:       hit = (done === 1'b0);
                2:       hit = (done === 1'b1);
                default: hit = (en_rng === 1'b1);
            endcase
            if (!hit) step();
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL %s: condition not reached within 60 cycles", name);
        end
    endtask

    // Generator: done drops on the accepting edge, rises two edges later with a fresh word.
    // Reference model: every completed generator word is stored (unless rejected), reads pop the oldest.
    always @(posedge clock) begin
        if (!nrst) begin
            done      <= 1'b0;
            rng_in    <= '0;
            gen_busy  <= 1'b0;
            gen_step  <= 1'b0;
            gen_fresh <= 1'b0;
            exp_q.delete();
        end else begin
            if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
            if (gen_fresh) begin
                gen_fresh <= 1'b0;
                if (!REJECT || int'(rng_in[WIDTH-1:0]) < LIMIT) exp_q.push_back(rng_in[WIDTH-1:0]);
            end
            if (en_rng) begin
                done     <= 1'b0;
                gen_busy <= 1'b1;
                gen_step <= 1'b0;
            end else if (gen_busy) begin
                if (!gen_step) begin
                    gen_step <= 1'b1;
                end else begin
                    gen_busy <= 1'b0;
                    if (!stuck) begin
                        done      <= 1'b1;
                        gen_fresh <= 1'b1;
                        if (gen_q.size() > 0) rng_in <= gen_q.pop_front();
                        else                  rng_in <= 16'($urandom);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (sb_on && nrst === 1'b1) begin
            check("sb_count", 32'(count), 32'(exp_q.size()));
            check("sb_valid", 32'(valid), 32'(exp_q.size() != 0));
            check("sb_full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("sb_rd_data", 32'(rd_data), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'd0);
            if (en_rng) begin
                check("en_single_cycle", 32'(en_prev), 32'd0);
                check("en_below_depth", 32'(count < DEPTH), 32'd1);
            end
        end
        en_prev <= en_rng;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int               en_cnt;
        bit               seen;
        logic [WIDTH-1:0] w;
        nrst  = 1'b0;
        run   = 1'b0;
        rd_en = 1'b0;
        stuck = 1'b0;
        sb_on = 1'b0;
        // cycle-by-cycle expectations after reset release with run=1
        vecs[0] = '{1'b0, 1'b0, 0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 0, 4'h0};
        vecs[2] = '{1'b0, 1'b0, 0, 4'h0};
        vecs[3] = '{1'b0, 1'b0, 0, 4'h0};
        vecs[4] = '{1'b0, 1'b0, 0, 4'h0};
        vecs[5] = '{1'b0, 1'b1, 1, 4'hB};
        vecs[6] = '{1'b1, 1'b1, 1, 4'hB};
        gen_q = '{16'h3A0B, 16'h1236, 16'hFFFD, 16'h800A, 16'h0004, 16'h7777, 16'hC0D1, 16'h0E09};

        repeat (3) step();
        @(negedge clock);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_en_rng", 32'(en_rng), 32'd0);
        step();
        nrst  = 1'b1;
        run   = 1'b1;
        sb_on = 1'b1;

        for (int i = 0; i <= 40; i++) begin
            @(negedge clock);
            if (i < 7) begin
                check($sformatf("vec%0d_en_rng", i), 32'(en_rng), 32'(vecs[i].en));
                check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].vld));
                check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
                check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            end
            if (i == 39) begin
                check("fill_c39_count", 32'(count), 32'd7);
                check("fill_c39_full", 32'(full), 32'd0);
            end
            if (i == 40) begin
                check("fill_c40_count", 32'(count), 32'd8);
                check("fill_c40_full", 32'(full), 32'd1);
            end
            step();
        end
        en_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (en_rng) en_cnt++;
            step();
        end
        check("full_no_request", 32'(en_cnt), 32'd0);

        // single pop from full
        @(negedge clock);
        check("head_before_pop", 32'(rd_data), 32'hB);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        seen  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (i == 1) begin
                check("head_after_pop", 32'(rd_data), 32'h6);
                check("count_after_pop", 32'(count), 32'd7);
            end
            if (i <= 2 && en_rng) seen = 1'b1;
            step();
        end
        check("request_after_pop", 32'(seen), 32'd1);
        @(negedge clock);
        check("refill_count", 32'(count), 32'd8);
        step();

        // drain, then read while empty
        run   = 1'b0;
        rd_en = 1'b1;
        repeat (10) step();
        @(negedge clock);
        check("empty_read_count", 32'(count), 32'd0);
        check("empty_read_rd_data", 32'(rd_data), 32'd0);
        step();
        @(negedge clock);
        check("empty_read_count2", 32'(count), 32'd0);
        check("empty_read_valid", 32'(valid), 32'd0);
        rd_en = 1'b0;
        step();

        // pop coincident with push at count == 1
        run = 1'b1;
        wait_for(0, "first_push");
        wait_for(1, "done_low");
        wait_for(2, "done_high");
        w     = rng_in[WIDTH-1:0];
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        @(negedge clock);
        check("coincident_count", 32'(count), 32'd1);
        check("coincident_head", 32'(rd_data), 32'(w));
        step();

        // run dropped in the cycle after REQ
        wait_for(3, "req_before_drop");
        step();
        run    = 1'b0;
        en_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (en_rng) en_cnt++;
            step();
        end
        check("drop_no_request", 32'(en_cnt), 32'd0);
        @(negedge clock);
        check("drop_value_pushed", 32'(count), 32'd2);
        step();
        run = 1'b1;
        wait_for(3, "resume_request");
        step();

        // generator timeout
        run = 1'b0;
        repeat (10) step();
        stuck = 1'b1;
        run   = 1'b1;
        wait_for(3, "timeout_request");
        for (int j = 1; j <= 16; j++) begin
            step();
            @(negedge clock);
            if (j == 14) check("err_before_timeout", 32'(err), 32'd0);
            if (j == 16) check("err_after_timeout", 32'(err), 32'd1);
        end
        step();
        wait_for(3, "retry_request");
        stuck = 1'b0;
        check("err_sticky_retry", 32'(err), 32'd1);
        step();

        // random traffic: fill-heavy first half, drain-heavy second half
        for (int i = 0; i < 1600; i++) begin
            run   = ($urandom_range(0, 7) != 0);
            rd_en = (i < 800) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            step();
        end
        @(negedge clock);
        check("err_sticky_end", 32'(err), 32'd1);
        step();
        nrst  = 1'b0;
        run   = 1'b0;
        rd_en = 1'b0;
        step();
        step();
        @(negedge clock);
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_valid", 32'(valid), 32'd0);
        check("rst2_en_rng", 32'(en_rng), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
